charging_eval_mc: RTL

- Multi-flow successor to the single-stream charging evaluation stage.
- Accepts classified packets (flow ID, length, counting policy, report threshold, UL/DL direction) from the upstream parser over a valid/ready handshake.
- Keeps per-flow uplink/downlink volume and packet counters in a small flow table.
- Issues a usage report over a second valid/ready handshake when a flow's counted volume reaches its threshold.

---
 rtl/charging_pkg.sv | 37 +++
 rtl/charging_flow_cam.sv | 62 ++++++
 rtl/charging_eval_mc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/charging_pkg.sv
// Shared definitions for the multi-flow charging evaluation stage:
// default widths, policy codes, FSM state type and a saturating adder.
package charging_pkg;

  localparam int DEF_ID_W      = 96;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_CNT_W     = 40;
  localparam int DEF_PKTC_W    = 24;
  localparam int DEF_NUM_FLOWS = 8;
  localparam int DEF_POL_W     = 3;
  localparam int DEF_THR_W     = 22;
  localparam int DEF_THR_SHIFT = 10;

  localparam logic [2:0] POL_NONE      = 3'd0;
  localparam logic [2:0] POL_TOTAL     = 3'd1;
  localparam logic [2:0] POL_UL        = 3'd2;
  localparam logic [2:0] POL_DL        = 3'd3;
  localparam logic [2:0] POL_TOTAL_RPT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Operands must be below 2^w with w <= 63, so the raw sum never wraps.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/charging_flow_cam.sv
// Flow key table: per-entry key/valid registers, parallel match against the
// lookup key, and lowest-free-index allocation.
module charging_flow_cam
  import charging_pkg::*;
#(
  parameter int ID_W      = DEF_ID_W,
  parameter int NUM_FLOWS = DEF_NUM_FLOWS,
  parameter int IDX_W     = $clog2(NUM_FLOWS)
) (
  input  logic             asclk,
  input  logic             aresetn,
  input  logic [ID_W-1:0]  lkp_key,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ID_W-1:0]  wr_key,
  input  logic             clr_all,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             free_ok,
  output logic [IDX_W-1:0] free_idx
);

  logic [ID_W-1:0]      key_q [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] valid_q, valid_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    if (clr_all)    valid_d = '0;
    else if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // NOTE: key storage has no reset; an entry's key is only looked at while its valid bit is set.
  always_ff @(posedge asclk) begin
    if (wr_en) key_q[wr_idx] <= wr_key;
  end

  // Scanning from the top down lets the lowest matching/free index win.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == lkp_key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/charging_eval_mc.sv
// Multi-flow charging evaluation: per-flow UL/DL volume and packet counters
// with threshold-triggered usage reports over a valid/ready handshake.
module charging_eval_mc
  import charging_pkg::*;
#(
  parameter int ID_W      = DEF_ID_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PKTC_W    = DEF_PKTC_W,
  parameter int NUM_FLOWS = DEF_NUM_FLOWS,
  parameter int POL_W     = DEF_POL_W,
  parameter int THR_W     = DEF_THR_W,
  parameter int THR_SHIFT = DEF_THR_SHIFT
) (
  input  logic              asclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   pkt_id,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [POL_W-1:0]  pkt_policy,
  input  logic [THR_W-1:0]  pkt_report,
  input  logic              pkt_ul,
  input  logic              pkt_vld,
  output logic              pkt_rdy,
  input  logic              clear_all,
  output logic              check_policy,
  output logic              drop_pulse,
  output logic [15:0]       drop_cnt,
  output logic              rpt_vld,
  input  logic              rpt_rdy,
  output logic [ID_W-1:0]   rpt_flow_id,
  output logic [CNT_W-1:0]  rpt_ul_vol,
  output logic [CNT_W-1:0]  rpt_dl_vol,
  output logic [PKTC_W-1:0] rpt_pkts
);

  localparam int IDX_W = $clog2(NUM_FLOWS);

  state_e            state_q, state_d;
  logic              init_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        pol_q, pol_d, pol_in;
  logic [THR_W-1:0]  thr_q, thr_d;
  logic              dir_ul_q, dir_ul_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              rpt_vld_q, rpt_vld_d;
  logic [ID_W-1:0]   rpt_id_q, rpt_id_d;
  logic [CNT_W-1:0]  rpt_ul_q, rpt_ul_d, rpt_dl_q, rpt_dl_d;
  logic [PKTC_W-1:0] rpt_pkts_q, rpt_pkts_d;

  logic [CNT_W-1:0]  ul_vol_q [NUM_FLOWS];
  logic [CNT_W-1:0]  dl_vol_q [NUM_FLOWS];
  logic [PKTC_W-1:0] pkts_q   [NUM_FLOWS];
  logic              ctr_we;
  logic [IDX_W-1:0]  ctr_idx;
  logic [CNT_W-1:0]  ctr_ul, ctr_dl;
  logic [PKTC_W-1:0] ctr_pkts;
  logic              cnt_ul, cnt_dl;

  logic              cam_hit, cam_free_ok, cam_wr_en, cam_clr;
  logic [IDX_W-1:0]  cam_hit_idx, cam_free_idx;

  charging_flow_cam #(.ID_W(ID_W), .NUM_FLOWS(NUM_FLOWS), .IDX_W(IDX_W)) u_cam (
    .asclk    (asclk),
    .aresetn  (aresetn),
    .lkp_key  (id_q),
    .wr_en    (cam_wr_en),
    .wr_idx   (cam_free_idx),
    .wr_key   (id_q),
    .clr_all  (cam_clr),
    .hit      (cam_hit),
    .hit_idx  (cam_hit_idx),
    .free_ok  (cam_free_ok),
    .free_idx (cam_free_idx)
  );

  assign pol_in  = 3'(pkt_policy);
  assign pkt_rdy = init_q && (state_q == ST_IDLE) && !clear_all;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    len_d        = len_q;
    pol_d        = pol_q;
    thr_d        = thr_q;
    dir_ul_d     = dir_ul_q;
    idx_d        = idx_q;
    drop_cnt_d   = drop_cnt_q;
    rpt_vld_d    = rpt_vld_q;
    rpt_id_d     = rpt_id_q;
    rpt_ul_d     = rpt_ul_q;
    rpt_dl_d     = rpt_dl_q;
    rpt_pkts_d   = rpt_pkts_q;
    ctr_we       = 1'b0;
    ctr_idx      = idx_q;
    ctr_ul       = '0;
    ctr_dl       = '0;
    ctr_pkts     = '0;
    cam_wr_en    = 1'b0;
    cam_clr      = 1'b0;
    drop_pulse   = 1'b0;
    check_policy = 1'b0;
    cnt_ul       = (pol_q == POL_TOTAL) || (pol_q == POL_TOTAL_RPT) || (pol_q == POL_UL);
    cnt_dl       = (pol_q == POL_TOTAL) || (pol_q == POL_TOTAL_RPT) || (pol_q == POL_DL);
    case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          cam_clr = 1'b1;
        end else if (pkt_rdy && pkt_vld) begin
          id_d     = pkt_id;
          len_d    = pkt_len;
          pol_d    = pol_in;
          thr_d    = pkt_report;
          dir_ul_d = pkt_ul;
          // NONE and reserved codes are consumed without touching the table.
          if (pol_in >= POL_TOTAL && pol_in <= POL_TOTAL_RPT) state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cam_hit) begin
          idx_d   = cam_hit_idx;
          state_d = ST_UPDATE;
        end else if (cam_free_ok) begin
          idx_d     = cam_free_idx;
          cam_wr_en = 1'b1;
          ctr_we    = 1'b1;
          ctr_idx   = cam_free_idx;
          state_d   = ST_UPDATE;
        end else begin
          drop_pulse = 1'b1;
          drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        check_policy = 1'b1;
        ctr_we       = 1'b1;
        ctr_ul       = ul_vol_q[idx_q];
        ctr_dl       = dl_vol_q[idx_q];
        ctr_pkts     = PKTC_W'(sat_add(64'(pkts_q[idx_q]), 64'd1, PKTC_W));
        if (dir_ul_q && cnt_ul)
          ctr_ul = CNT_W'(sat_add(64'(ul_vol_q[idx_q]), 64'(len_q), CNT_W));
        if (!dir_ul_q && cnt_dl)
          ctr_dl = CNT_W'(sat_add(64'(dl_vol_q[idx_q]), 64'(len_q), CNT_W));
        state_d = ST_IDLE;
        if ((pol_q == POL_TOTAL_RPT) && (thr_q != '0) &&
            ((64'(ctr_ul) + 64'(ctr_dl)) >= (64'(thr_q) << THR_SHIFT))) begin
          rpt_vld_d  = 1'b1;
          rpt_id_d   = id_q;
          rpt_ul_d   = ctr_ul;
          rpt_dl_d   = ctr_dl;
          rpt_pkts_d = ctr_pkts;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (rpt_rdy) begin
          ctr_we    = 1'b1;
          rpt_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      pol_q      <= POL_NONE;
      thr_q      <= '0;
      dir_ul_q   <= 1'b0;
      idx_q      <= '0;
      drop_cnt_q <= '0;
      rpt_vld_q  <= 1'b0;
      rpt_id_q   <= '0;
      rpt_ul_q   <= '0;
      rpt_dl_q   <= '0;
      rpt_pkts_q <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      id_q       <= id_d;
      len_q      <= len_d;
      pol_q      <= pol_d;
      thr_q      <= thr_d;
      dir_ul_q   <= dir_ul_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
      rpt_vld_q  <= rpt_vld_d;
      rpt_id_q   <= rpt_id_d;
      rpt_ul_q   <= rpt_ul_d;
      rpt_dl_q   <= rpt_dl_d;
      rpt_pkts_q <= rpt_pkts_d;
    end
  end

  // Counters are zeroed on allocation and after a report, so they need no reset.
  always_ff @(posedge asclk) begin
    if (ctr_we) begin
      ul_vol_q[ctr_idx] <= ctr_ul;
      dl_vol_q[ctr_idx] <= ctr_dl;
      pkts_q[ctr_idx]   <= ctr_pkts;
    end
  end

  assign drop_cnt    = drop_cnt_q;
  assign rpt_vld     = rpt_vld_q;
  assign rpt_flow_id = rpt_id_q;
  assign rpt_ul_vol  = rpt_ul_q;
  assign rpt_dl_vol  = rpt_dl_q;
  assign rpt_pkts    = rpt_pkts_q;

endmodule
